mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Back end of the PIGRO pipeline; consumes the execute stage's result bundle (ALU/CMP result, opcode, destination, immediate flag, address).
- Arithmetic, logic and CMP results: registered write into the register file.
- LDW/STR: multi-cycle req/ack transaction on the data-memory port; LDW read data is written back afterwards.
- Asserts stall toward upstream while a memory transaction is outstanding.
- Exposes the write-back bus for forwarding into the read stage.

Parameters:
ADDR_W, 8, data-memory address width
TIMEOUT, 16, max cycles to wait for dmem_ack; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  EX bundle valid this cycle
ex_opcode  in  5  opcode, encoded per the team opcode header (NOP, arithmetic/logic range NOP<op<=ARSH, LDW, STR, CMP, BRQ/BRG/BRS)
ex_data  in  32  ALU/CMP result, LDW immediate, or STR store data
ex_addr  in  ADDR_W  data-memory address for LDW/STR
ex_dest  in  4  destination register
ex_isimm  in  1  1: LDW loads ex_data directly, no memory access
ex_error  in  1  ALU error flag for this bundle
in_ready  out  1  stage can accept a bundle (1 only in IDLE)
stall  out  1  ~in_ready
dmem_req  out  1  memory request
dmem_we  out  1  1=store, 0=load; valid with dmem_req
dmem_addr  out  ADDR_W  request address
dmem_wdata  out  32  store data
dmem_ack  in  1  request completed this cycle
dmem_rdata  in  32  load data, valid with dmem_ack
rf_we  out  1  register-file write strobe, one-cycle pulse
rf_waddr  out  4  write address
rf_wdata  out  32  write data (also forwarding bus)
store_done  out  1  one-cycle pulse on store ack
mem_error  out  1  sticky: memory timeout occurred
exc  out  1  sticky: arithmetic bundle arrived with ex_error=1

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0 except in_ready=1; timeout counter=0; captured bundle cleared.
- Reset in any state, including mid-transaction: dmem_req drops at the next edge; no rf_we; sticky flags cleared.
- States: IDLE, REQ, WB.
- Accept: ex_valid & in_ready at edge N.
  - Arithmetic/logic, CMP, or LDW with ex_isimm=1: stay IDLE.
    - Cycle N+1: rf_we=1, rf_waddr=ex_dest, rf_wdata=ex_data.
    - Back-to-back accepts every cycle allowed.
    - CMP value is already zero-extended by EX; pass through unchanged.
  - Arithmetic with ex_error=1: no rf_we; exc set at N+1.
  - NOP, BRQ/BRG/BRS, undefined opcodes: no rf_we, no memory action.
  - LDW (ex_isimm=0) or STR: go to REQ.
    - From N+1: dmem_req=1, dmem_addr=ex_addr; dmem_we=1 for STR with dmem_wdata=ex_data; dmem_we=0 for LDW.
    - Request fields stay stable until ack or abort.
- REQ:
  - dmem_ack is sampled only while dmem_req=1; ack in IDLE/WB is ignored.
  - On ack, LDW: capture dmem_rdata, go to WB, dmem_req=0 next cycle.
  - On ack, STR: store_done pulse next cycle, go to IDLE.
  - Timeout counter increments each REQ cycle without ack. At TIMEOUT, with no ack by the TIMEOUT-th REQ cycle: dmem_req=0, mem_error=1 (sticky), go to IDLE, no write.
  - Ack on the same edge as expiry wins (normal completion).
  - Counter clears on leaving REQ.
- WB: rf_we=1, rf_waddr=captured dest, rf_wdata=captured rdata for one cycle, then IDLE.
- LDW latency: ack in cycle N+k, rf_we in cycle N+k+1, in_ready=1 from cycle N+k+2.
- in_ready is a function of state only, never of dmem_ack.
- Upstream must hold its bundle while stall=1.
- rf_we is never asserted with an X address. Register 0 is writable like any other register.

Test Plan:
1. ADD bundle, ex_data=0x00000007, dest=3 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0x7 for exactly 1 cycle; then SUB dest=4 accepted the following cycle also writes.
2. LDW isimm=0, ex_addr=0x10, dest=5; ack after 3 REQ cycles with rdata=0xDEADBEEF → dmem_req=1 and dmem_we=0 for 3 cycles, rf_we with 0xDEADBEEF to r5 one cycle after ack, in_ready=0 throughout.
3. STR ex_data=0x12345678, ex_addr=0x20, ack in first REQ cycle → dmem_we=1, dmem_wdata=0x12345678, store_done pulse, rf_we never asserted.
4. TIMEOUT=4, LDW with no ack → dmem_req high exactly 4 cycles, then 0; mem_error=1 stays set; no rf_we; next bundle accepted.
5. rst asserted in second REQ cycle, ack arriving after reset → dmem_req=0 at the next edge, in_ready=1, no rf_we, mem_error=0; stray ack ignored.
6. NOP, BRQ, and ADD with ex_error=1 → no rf_we for any of them; exc=1 after the ADD; LDW isimm=1 ex_data=0xFFFFFFF0 dest=2 → immediate write to r2 in 1 cycle, no dmem_req.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory / write-back stage of the PIGRO pipeline: registered register-file writes,
// LDW/STR req/ack data-memory transactions with timeout, and upstream stall.
module mem_wb_stage #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [31:0]       ex_data,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [3:0]        ex_dest,
  input  logic              ex_isimm,
  input  logic              ex_error,
  output logic              in_ready,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              store_done,
  output logic              mem_error,
  output logic              exc
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ARSH = 5'd9;
  localparam logic [4:0] OP_LDW  = 5'd10;
  localparam logic [4:0] OP_STR  = 5'd11;
  localparam logic [4:0] OP_CMP  = 5'd12;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  state_t              state, state_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          dest_q, dest_d;
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic                rf_we_q, rf_we_d;
  logic [3:0]          rf_waddr_q, rf_waddr_d;
  logic [31:0]         rf_wdata_q, rf_wdata_d;
  logic                store_done_q, store_done_d;
  logic                mem_error_q, mem_error_d;
  logic                exc_q, exc_d;
  logic                is_arith;
  logic                accept;

  assign is_arith = (ex_opcode > OP_NOP) && (ex_opcode <= OP_ARSH);
  assign accept   = ex_valid && (state == IDLE);

  always_comb begin
    state_d      = state;
    req_we_d     = req_we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dest_d       = dest_q;
    tcnt_d       = tcnt_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    store_done_d = 1'b0;
    mem_error_d  = mem_error_q;
    exc_d        = exc_q;

    case (state)
      IDLE: begin
        if (accept) begin
          if ((is_arith && !ex_error) || (ex_opcode == OP_CMP) ||
              ((ex_opcode == OP_LDW) && ex_isimm)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex_dest;
            rf_wdata_d = ex_data;
          end else if (is_arith) begin
            exc_d = 1'b1;
          end else if ((ex_opcode == OP_LDW) || (ex_opcode == OP_STR)) begin
            state_d  = REQ;
            req_we_d = (ex_opcode == OP_STR);
            addr_d   = ex_addr;
            wdata_d  = (ex_opcode == OP_STR) ? ex_data : '0;
            dest_d   = ex_dest;
            tcnt_d   = '0;
          end
        end
      end

      REQ: begin
        // Ack is checked before expiry so an ack on the final allowed cycle completes normally.
        if (dmem_ack) begin
          tcnt_d   = '0;
          req_we_d = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          if (req_we_q) begin
            store_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d    = WB;
            rf_we_d    = 1'b1;
            rf_waddr_d = dest_q;
            rf_wdata_d = dmem_rdata;
          end
        end else if ((TIMEOUT != 0) && (tcnt_q == CW'(TIMEOUT - 1))) begin
          state_d     = IDLE;
          mem_error_d = 1'b1;
          tcnt_d      = '0;
          req_we_d    = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dest_q       <= '0;
      tcnt_q       <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      store_done_q <= 1'b0;
      mem_error_q  <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state        <= state_d;
      req_we_q     <= req_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dest_q       <= dest_d;
      tcnt_q       <= tcnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      store_done_q <= store_done_d;
      mem_error_q  <= mem_error_d;
      exc_q        <= exc_d;
    end
  end

  assign in_ready   = (state == IDLE);
  assign stall      = ~in_ready;
  assign dmem_req   = (state == REQ);
  assign dmem_we    = req_we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign store_done = store_done_q;
  assign mem_error  = mem_error_q;
  assign exc        = exc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: randomized bundles checked against rule-based expectations.
module tb_mem_wb_stage;
  localparam int ADDR_W = 8;
  localparam int TMO    = 4;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_LDW = 5'd10;
  localparam logic [4:0] OP_STR = 5'd11;
  localparam logic [4:0] OP_CMP = 5'd12;
  localparam logic [4:0] OP_BRQ = 5'd13;
  localparam logic [4:0] OP_BRG = 5'd14;
  localparam logic [4:0] OP_BRS = 5'd15;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [4:0]        ex_opcode;
  logic [31:0]       ex_data;
  logic [ADDR_W-1:0] ex_addr;
  logic [3:0]        ex_dest;
  logic              ex_isimm;
  logic              ex_error;
  logic              in_ready, stall;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              store_done, mem_error, exc;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_data(ex_data), .ex_addr(ex_addr),
    .ex_dest(ex_dest), .ex_isimm(ex_isimm), .ex_error(ex_error),
    .in_ready(in_ready), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .store_done(store_done), .mem_error(mem_error), .exc(exc)
  );

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_opcode = OP_NOP; ex_data = '0; ex_addr = '0;
    ex_dest = '0; ex_isimm = 1'b0; ex_error = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [82:0] rest;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rest = {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, rf_we, rf_waddr, rf_wdata,
            store_done, mem_error, exc};
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    nvec++; if (rest !== '0) begin nerr++; $display("FAIL reset_outputs got %h exp 0", rest); end
    rst = 1'b0;
  endtask

  task automatic test_alu_b2b();
    logic [4:0]  op;
    logic [31:0] d;
    logic [3:0]  a;
    for (int i = 0; i < 32; i++) begin
      if (i == 0)      begin op = OP_ADD; d = 32'h7; a = 4'd3; end
      else if (i == 1) begin op = OP_SUB; d = $urandom; a = 4'd4; end
      else if (i == 2) begin op = 5'($urandom_range(1, 9)); d = $urandom; a = 4'd0; end
      else begin
        op = ($urandom_range(0, 3) == 0) ? OP_CMP : 5'($urandom_range(1, 9));
        d = $urandom; a = 4'($urandom);
      end
      if (op == OP_CMP) d = {31'b0, d[0]};
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL alu_ready[%0d] got %b exp 1", i, in_ready); end
      ex_valid = 1'b1; ex_opcode = op; ex_data = d; ex_dest = a; ex_addr = 8'($urandom);
      ex_isimm = 1'($urandom); ex_error = 1'b0;
      @(posedge clk); @(negedge clk);
      nvec++; if (rf_we !== 1'b1) begin nerr++; $display("FAIL alu_we[%0d] got %b exp 1", i, rf_we); end
      nvec++; if (rf_waddr !== a) begin nerr++; $display("FAIL alu_waddr[%0d] got %0d exp %0d", i, rf_waddr, a); end
      nvec++; if (rf_wdata !== d) begin nerr++; $display("FAIL alu_wdata[%0d] got %h exp %h", i, rf_wdata, d); end
      nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL alu_noreq[%0d] got %b exp 0", i, dmem_req); end
    end
    idle_inputs();
    @(posedge clk); @(negedge clk);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL alu_pulse_end got %b exp 0", rf_we); end
  endtask

  task automatic test_mem();
    logic              st, completes, exp_merr, exp_ready, exp_req, exp_wr, exp_sd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data, rdata;
    logic [3:0]        dest;
    int                ack_at, n_req, n_busy;
    exp_merr = 1'b0;
    for (int t = 0; t < 24; t++) begin
      if (t == 0)      begin st = 1'b0; addr = 8'h40; data = $urandom; dest = 4'd6; rdata = $urandom; ack_at = 0; end
      else if (t == 1) begin st = 1'b0; addr = 8'h10; data = $urandom; dest = 4'd5; rdata = 32'hDEADBEEF; ack_at = 3; end
      else if (t == 2) begin st = 1'b1; addr = 8'h20; data = 32'h12345678; dest = 4'($urandom); rdata = $urandom; ack_at = 1; end
      else begin
        st = 1'($urandom); addr = 8'($urandom); data = $urandom; dest = 4'($urandom);
        rdata = $urandom; ack_at = $urandom_range(0, 5);
        if (ack_at == 5) ack_at = $urandom_range(1, TMO);
      end
      completes = (ack_at != 0);
      n_req  = completes ? ack_at : TMO;
      n_busy = !completes ? TMO : (st ? ack_at : ack_at + 1);
      ex_valid = 1'b1; ex_opcode = st ? OP_STR : OP_LDW; ex_data = data; ex_addr = addr;
      ex_dest = dest; ex_isimm = 1'b0; ex_error = 1'b0;
      @(posedge clk); @(negedge clk);
      ex_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        exp_ready = (c > n_busy);
        exp_req   = (c <= n_req);
        exp_wr    = completes && !st && (c == ack_at + 1);
        exp_sd    = completes && st && (c == ack_at + 1);
        nvec++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL mem_ready[%0d.%0d] got %b exp %b", t, c, in_ready, exp_ready); end
        nvec++; if (stall !== !exp_ready) begin nerr++; $display("FAIL mem_stall[%0d.%0d] got %b exp %b", t, c, stall, !exp_ready); end
        nvec++; if (dmem_req !== exp_req) begin nerr++; $display("FAIL mem_req[%0d.%0d] got %b exp %b", t, c, dmem_req, exp_req); end
        nvec++; if (rf_we !== exp_wr) begin nerr++; $display("FAIL mem_rfwe[%0d.%0d] got %b exp %b", t, c, rf_we, exp_wr); end
        nvec++; if (store_done !== exp_sd) begin nerr++; $display("FAIL mem_sdone[%0d.%0d] got %b exp %b", t, c, store_done, exp_sd); end
        if (exp_req) begin
          nvec++; if (dmem_addr !== addr) begin nerr++; $display("FAIL mem_addr[%0d.%0d] got %h exp %h", t, c, dmem_addr, addr); end
          nvec++; if (dmem_we !== st) begin nerr++; $display("FAIL mem_we[%0d.%0d] got %b exp %b", t, c, dmem_we, st); end
          if (st) begin
            nvec++; if (dmem_wdata !== data) begin nerr++; $display("FAIL mem_wdata[%0d.%0d] got %h exp %h", t, c, dmem_wdata, data); end
          end
        end
        if (exp_wr) begin
          nvec++; if (rf_waddr !== dest) begin nerr++; $display("FAIL ldw_waddr[%0d] got %0d exp %0d", t, rf_waddr, dest); end
          nvec++; if (rf_wdata !== rdata) begin nerr++; $display("FAIL ldw_wdata[%0d] got %h exp %h", t, rf_wdata, rdata); end
        end
        dmem_ack   = (c == ack_at);
        dmem_rdata = (c == ack_at) ? rdata : $urandom;
        @(posedge clk); @(negedge clk);
      end
      dmem_ack = 1'b0;
      if (!completes) exp_merr = 1'b1;
      nvec++; if (mem_error !== exp_merr) begin nerr++; $display("FAIL mem_error[%0d] got %b exp %b", t, mem_error, exp_merr); end
    end
  endtask

  task automatic test_reset_midtxn();
    ex_valid = 1'b1; ex_opcode = OP_LDW; ex_data = $urandom; ex_addr = 8'($urandom);
    ex_dest = 4'd9; ex_isimm = 1'b0; ex_error = 1'b0;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL rmid_req1 got %b exp 1", dmem_req); end
    @(posedge clk); @(negedge clk);
    nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL rmid_req2 got %b exp 1", dmem_req); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL rmid_req_drop got %b exp 0", dmem_req); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
    nvec++; if (mem_error !== 1'b0) begin nerr++; $display("FAIL rmid_merr got %b exp 0", mem_error); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL rmid_rfwe got %b exp 0", rf_we); end
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL stray_ack_rfwe[%0d] got %b exp 0", c, rf_we); end
      nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL stray_ack_req[%0d] got %b exp 0", c, dmem_req); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stray_ack_ready[%0d] got %b exp 1", c, in_ready); end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_no_write();
    logic [4:0] ops [8];
    logic       err_bundle;
    logic       exp_exc;
    ops[0] = OP_NOP; ops[1] = OP_BRQ; ops[2] = OP_BRG; ops[3] = OP_BRS;
    ops[4] = 5'($urandom_range(16, 31)); ops[5] = 5'($urandom_range(16, 31));
    ops[6] = 5'($urandom_range(16, 31)); ops[7] = OP_ADD;
    exp_exc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      err_bundle = (i == 7);
      ex_valid = 1'b1; ex_opcode = ops[i]; ex_data = $urandom; ex_addr = 8'($urandom);
      ex_dest = 4'($urandom); ex_isimm = 1'b0; ex_error = err_bundle;
      @(posedge clk); @(negedge clk);
      if (err_bundle) exp_exc = 1'b1;
      nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL nowr_rfwe[%0d] got %b exp 0", i, rf_we); end
      nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL nowr_req[%0d] got %b exp 0", i, dmem_req); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL nowr_ready[%0d] got %b exp 1", i, in_ready); end
      nvec++; if (exc !== exp_exc) begin nerr++; $display("FAIL nowr_exc[%0d] got %b exp %b", i, exc, exp_exc); end
    end
    ex_valid = 1'b1; ex_opcode = OP_LDW; ex_data = 32'hFFFFFFF0; ex_addr = 8'($urandom);
    ex_dest = 4'd2; ex_isimm = 1'b1; ex_error = 1'b0;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    nvec++; if (rf_we !== 1'b1) begin nerr++; $display("FAIL ldimm_we got %b exp 1", rf_we); end
    nvec++; if (rf_waddr !== 4'd2) begin nerr++; $display("FAIL ldimm_waddr got %0d exp 2", rf_waddr); end
    nvec++; if (rf_wdata !== 32'hFFFFFFF0) begin nerr++; $display("FAIL ldimm_wdata got %h exp fffffff0", rf_wdata); end
    nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL ldimm_req got %b exp 0", dmem_req); end
    nvec++; if (exc !== 1'b1) begin nerr++; $display("FAIL exc_sticky got %b exp 1", exc); end
    @(posedge clk); @(negedge clk);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL ldimm_pulse_end got %b exp 0", rf_we); end
    nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL ldimm_req_after got %b exp 0", dmem_req); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_b2b();
    test_mem();
    test_reset_midtxn();
    test_no_write();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
